// File: rtl/uart_pkg.sv
// Shared definitions for the UART channel: parity modes, receive FSM states, bus width.
package uart_pkg;

  // Parity modes selected by the PARITY parameter
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width of the memory-mapped read bus
  localparam int BUS_WIDTH = 32;

  // Receive FSM states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud tick generator: counts 0..Div while enabled and pulses Tick on the terminal count.
// Held at zero while disabled so the tick phase starts fresh from the enable edge.
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [DIV_WIDTH-1:0] Div,
  output logic                 Tick
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] count_reg;
  logic [DIV_WIDTH-1:0] count_next;

  // Next count: wrap to zero on the terminal count or whenever disabled
  always_comb begin
    count_next = '0;
    if (En && (count_reg != Div)) begin
      count_next = count_reg + CNT_ONE;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign Tick = En && (count_reg == Div);

endmodule

// File: rtl/uart_rx_frame_receiver.sv
// UART receive channel: synchronises the serial line, recovers start/data/parity/stop
// with oversampled mid-bit sampling, and holds each word behind a valid/ack handshake
// on a tri-state 32-bit read port.
module uart_rx_frame_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [DIV_WIDTH-1:0] BaudDiv,
  input  logic                 SerIn,
  input  logic                 OE,
  input  logic                 Ack,
  output logic [BUS_WIDTH-1:0] Dout,
  output logic                 Valid,
  output logic                 FrameErr,
  output logic                 ParityErr,
  output logic                 Overrun,
  output logic                 Busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  rx_state_t            state_reg, state_next;
  logic [1:0]           sync_reg;
  logic                 rx;
  logic                 tick;
  logic                 mid_bit;
  logic                 load;
  logic [SW-1:0]        samp_reg, samp_next;
  logic [BW-1:0]        bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 perr_calc_reg, perr_calc_next;
  logic [DATA_BITS-1:0] held_reg, held_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 perr_reg, perr_next;
  logic                 ovr_reg, ovr_next;

  // Two-flop synchroniser for the asynchronous line; resets to the idle level
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], SerIn};
    end
  end

  assign rx = sync_reg[1];

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .Clock (Clock),
    .Reset (Reset),
    .En    (state_reg != ST_IDLE),
    .Div   (BaudDiv),
    .Tick  (tick)
  );

  // Mid-bit point for the data, parity and stop bits
  assign mid_bit = tick && (samp_reg == S_LAST);

  // Frame FSM next-state and sampling datapath
  always_comb begin
    state_next     = state_reg;
    samp_next      = samp_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    perr_calc_next = perr_calc_reg;
    load           = 1'b0;

    // After the start bit, the sample counter free-runs 0..OVERSAMPLE-1 per bit
    if (tick && (state_reg != ST_IDLE) && (state_reg != ST_START)) begin
      samp_next = (samp_reg == S_LAST) ? '0 : samp_reg + S_ONE;
    end

    case (state_reg)
      ST_IDLE: begin
        samp_next = '0;
        bit_next  = '0;
        if (!rx) begin
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (samp_reg == S_HALF) begin
            // A start bit that is high again at its midpoint was only a glitch
            samp_next  = '0;
            state_next = rx ? ST_IDLE : ST_DATA;
          end else begin
            samp_next = samp_reg + S_ONE;
          end
        end
      end
      ST_DATA: begin
        if (mid_bit) begin
          shift_next = {rx, shift_reg[DATA_BITS-1:1]};
          if (bit_reg == B_LAST) begin
            state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + B_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (mid_bit) begin
          perr_calc_next = (PARITY == PAR_EVEN) ? (^{shift_reg, rx}) : ~(^{shift_reg, rx});
          state_next     = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid_bit) begin
          load       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Holding register and handshake: an unacknowledged word is never overwritten
  always_comb begin
    held_next  = held_reg;
    valid_next = valid_reg;
    ferr_next  = ferr_reg;
    perr_next  = perr_reg;
    ovr_next   = ovr_reg;

    if (valid_reg && Ack) begin
      valid_next = 1'b0;
      ovr_next   = 1'b0;
    end

    if (load) begin
      if (valid_reg && !Ack) begin
        ovr_next = 1'b1;
      end else begin
        held_next  = shift_reg;
        ferr_next  = ~rx;
        perr_next  = perr_calc_reg;
        valid_next = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_reg     <= ST_IDLE;
      samp_reg      <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      perr_calc_reg <= 1'b0;
      held_reg      <= '0;
      valid_reg     <= 1'b0;
      ferr_reg      <= 1'b0;
      perr_reg      <= 1'b0;
      ovr_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      samp_reg      <= samp_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      perr_calc_reg <= perr_calc_next;
      held_reg      <= held_next;
      valid_reg     <= valid_next;
      ferr_reg      <= ferr_next;
      perr_reg      <= perr_next;
      ovr_reg       <= ovr_next;
    end
  end

  assign Valid     = valid_reg;
  assign FrameErr  = ferr_reg;
  assign ParityErr = perr_reg;
  assign Overrun   = ovr_reg;
  assign Busy      = (state_reg != ST_IDLE);
  assign Dout      = OE ? {{(BUS_WIDTH - DATA_BITS){1'b0}}, held_reg} : {BUS_WIDTH{1'bz}};

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Bench for the UART receiver: three instances (8N1, 7-bit even, 9-bit odd) driven by
// directed and randomized frames, compared against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] baud;
  logic [2:0]  ser;
  logic [2:0]  ack;
  logic        oe0;
  wire  [31:0] dout0, dout1, dout2;
  wire  [2:0]  valid_w, ferr_w, perr_w, ovr_w, busy_w;

  always #5 clk = ~clk;

  uart_rx_frame_receiver #(.DATA_BITS(8), .PARITY(0)) dut0 (
    .Clock(clk), .Reset(rst_n), .BaudDiv(baud), .SerIn(ser[0]), .OE(oe0), .Ack(ack[0]),
    .Dout(dout0), .Valid(valid_w[0]), .FrameErr(ferr_w[0]), .ParityErr(perr_w[0]),
    .Overrun(ovr_w[0]), .Busy(busy_w[0]));

  uart_rx_frame_receiver #(.DATA_BITS(7), .PARITY(1)) dut1 (
    .Clock(clk), .Reset(rst_n), .BaudDiv(baud), .SerIn(ser[1]), .OE(1'b1), .Ack(ack[1]),
    .Dout(dout1), .Valid(valid_w[1]), .FrameErr(ferr_w[1]), .ParityErr(perr_w[1]),
    .Overrun(ovr_w[1]), .Busy(busy_w[1]));

  uart_rx_frame_receiver #(.DATA_BITS(9), .PARITY(2)) dut2 (
    .Clock(clk), .Reset(rst_n), .BaudDiv(baud), .SerIn(ser[2]), .OE(1'b1), .Ack(ack[2]),
    .Dout(dout2), .Valid(valid_w[2]), .FrameErr(ferr_w[2]), .ParityErr(perr_w[2]),
    .Overrun(ovr_w[2]), .Busy(busy_w[2]));

  // Transaction-level model of each instance's visible state
  logic        mv [3];
  logic [31:0] mw [3];
  logic        mf [3];
  logic        mp [3];
  logic        mo [3];

  int checks   = 0;
  int failures = 0;

  int unsigned cyc = 0;
  int unsigned last_start = 0;
  int unsigned rise_cyc = 0;
  logic        v0_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Record the cycle on which dut0 raises Valid
  always @(negedge clk) begin
    if (valid_w[0] && !v0_prev) rise_cyc = cyc;
    v0_prev = valid_w[0];
  end

  function automatic int db_of(input int k);
    case (k)
      0:       return 8;
      1:       return 7;
      default: return 9;
    endcase
  endfunction

  function automatic int par_of(input int k);
    return k;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      mv[k] = 1'b0; mw[k] = '0; mf[k] = 1'b0; mp[k] = 1'b0; mo[k] = 1'b0;
    end
  endtask

  task automatic check_dut(input int k);
    logic [31:0] d;
    case (k)
      0:       d = dout0;
      1:       d = dout1;
      default: d = dout2;
    endcase
    check_val($sformatf("d%0d_valid", k), {31'b0, valid_w[k]}, {31'b0, mv[k]});
    check_val($sformatf("d%0d_ferr", k),  {31'b0, ferr_w[k]},  {31'b0, mf[k]});
    check_val($sformatf("d%0d_perr", k),  {31'b0, perr_w[k]},  {31'b0, mp[k]});
    check_val($sformatf("d%0d_ovr", k),   {31'b0, ovr_w[k]},   {31'b0, mo[k]});
    check_val($sformatf("d%0d_busy", k),  {31'b0, busy_w[k]},  32'd0);
    if (k != 0 || oe0) check_val($sformatf("d%0d_dout", k), d, mw[k]);
  endtask

  task automatic do_ack(input int k);
    ack[k] = 1'b1;
    wait_clks(1);
    ack[k] = 1'b0;
    wait_clks(1);
    if (mv[k]) begin
      mv[k] = 1'b0;
      mo[k] = 1'b0;
    end
  endtask

  // Serialise one frame LSB first; the stop level is held for 3/4 of a bit, then idle
  task automatic send_frame(input int k, input logic [31:0] data, input logic par_bad,
                            input logic stop_bit, input logic ack_at_load);
    int          b  = 16 * (int'(baud) + 1);
    int          nd = db_of(k);
    int          p  = par_of(k);
    logic [31:0] dm;
    logic        par_bit;
    dm = data & ((32'd1 << nd) - 32'd1);
    $display("frame dut=%0d baud=%0d data=%0h par_bad=%0b stop=%0b ack_at_load=%0b",
             k, baud, dm, par_bad, stop_bit, ack_at_load);
    last_start = cyc;
    ser[k] = 1'b0;
    wait_clks(b);
    for (int i = 0; i < nd; i++) begin
      ser[k] = dm[i];
      wait_clks(b);
    end
    if (p != 0) begin
      par_bit = (^dm) ^ (p == 2) ^ par_bad;
      ser[k] = par_bit;
      wait_clks(b);
    end
    ser[k] = stop_bit;
    if (ack_at_load) begin
      wait_clks(2 + b / 2);
      ack[k] = 1'b1;
      wait_clks(1);
      ack[k] = 1'b0;
      wait_clks((b * 3) / 4 - 3 - b / 2);
    end else begin
      wait_clks((b * 3) / 4);
    end
    ser[k] = 1'b1;
    wait_clks(b);
    if (mv[k] && !ack_at_load) begin
      mo[k] = 1'b1;
    end else begin
      mv[k] = 1'b1;
      mw[k] = dm;
      mf[k] = ~stop_bit;
      mp[k] = (p != 0) && par_bad;
      mo[k] = 1'b0;
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          b;
    int          k;
    logic [31:0] dat;
    rst_n = 1'b0; ser = 3'b111; ack = 3'b000; oe0 = 1'b1; baud = 16'd0;
    model_reset();
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(2);
    for (int i = 0; i < 3; i++) check_dut(i);

    // Clean 8N1 frame with exact latency from the start edge
    send_frame(0, 32'hA5, 1'b0, 1'b1, 1'b0);
    check_val("latency", rise_cyc - last_start, 32'd155);
    check_dut(0);
    do_ack(0);
    check_dut(0);

    // Short low pulse is rejected as a glitch
    ser[0] = 1'b0;
    wait_clks(4);
    check_val("glitch_busy", {31'b0, busy_w[0]}, 32'd1);
    ser[0] = 1'b1;
    wait_clks(32);
    check_dut(0);

    // Framing error
    send_frame(0, 32'h3C, 1'b0, 1'b0, 1'b0);
    check_dut(0);
    do_ack(0);
    check_dut(0);

    // Even parity, 7 bits: bad then good parity bit
    send_frame(1, 32'h01, 1'b1, 1'b1, 1'b0);
    check_dut(1);
    do_ack(1);
    send_frame(1, 32'h01, 1'b0, 1'b1, 1'b0);
    check_dut(1);
    do_ack(1);

    // Overrun keeps the first word
    send_frame(0, 32'h11, 1'b0, 1'b1, 1'b0);
    send_frame(0, 32'h22, 1'b0, 1'b1, 1'b0);
    check_dut(0);
    do_ack(0);
    check_dut(0);
    send_frame(0, 32'h33, 1'b0, 1'b1, 1'b0);
    check_dut(0);

    // Ack on the load cycle takes the new word without overrun
    send_frame(0, 32'h55, 1'b0, 1'b1, 1'b1);
    check_dut(0);
    do_ack(0);

    // Reset in the middle of the data bits, with the output port disabled
    oe0 = 1'b0;
    b = 16;
    ser[0] = 1'b0;
    wait_clks(b);
    for (int i = 0; i < 3; i++) begin
      ser[0] = i[0];
      wait_clks(b);
    end
    check_val("midframe_busy", {31'b0, busy_w[0]}, 32'd1);
    rst_n = 1'b0;
    wait_clks(2);
    ser[0] = 1'b1;
    rst_n = 1'b1;
    model_reset();
    wait_clks(2 * b);
    for (int i = 0; i < 3; i++) check_dut(i);
    send_frame(0, 32'h5A, 1'b0, 1'b1, 1'b0);
    check_dut(0);
    check_val("dout_hiz", {31'b0, (dout0 === 32'h5A)}, 32'd0);
    oe0 = 1'b1;
    wait_clks(1);
    check_dut(0);

    // Randomized frames across all three instances
    for (int n = 0; n < 40; n++) begin
      k    = int'($urandom_range(0, 2));
      baud = 16'($urandom_range(0, 2));
      dat  = $urandom;
      if ($urandom_range(0, 1) == 1) do_ack(k);
      send_frame(k, dat, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) == 0));
      check_dut(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
